alu_iter: RTL

Execute-stage ALU driven by the 4-bit ALU control code from `alu_control`. It performs single-cycle logic, arithmetic, shift and compare operations, plus a 32-iteration shift-add signed multiply that produces a 64-bit HI/LO product. Results are registered. A ready/valid handshake lets the pipeline control stall issue while a multiply is in flight.

---
 rtl/alu_iter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// alu_iter: execute-stage ALU. Single-cycle logic/arithmetic/shift/compare
// operations plus an iterative shift-add signed multiply producing a
// 2*DATA_W-bit HI/LO product. Results are registered; a ready/valid
// handshake stalls issue while a multiply is in flight.
module alu_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [4:0]        shamt,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] hi,
  output logic              zero
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd12;

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, MUL} state_t;

  // Single-cycle operations; undefined codes yield zero.
  function automatic logic [DATA_W-1:0] alu_op(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [4:0]        sh
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_AND:  alu_op = a & b;
      OP_OR:   alu_op = a | b;
      OP_ADD:  alu_op = a + b;
      OP_SLL:  alu_op = b << sh;
      OP_SRL:  alu_op = b >> sh;
      OP_SUB:  alu_op = a - b;
      OP_SLT:  alu_op = {{(DATA_W-1){1'b0}}, (sa < sb)};
      OP_NOR:  alu_op = ~(a | b);
      default: alu_op = '0;
    endcase
  endfunction

  // Magnitude of a signed operand; the most negative value maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    abs_val = v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

  // Two's-complement negation of a full-width product.
  function automatic logic [2*DATA_W-1:0] neg_prod(input logic [2*DATA_W-1:0] p);
    neg_prod = ~p + (2*DATA_W)'(1);
  endfunction

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     mcand;
  logic [DATA_W-1:0]     mplier;
  logic                  sign;
  logic [2*DATA_W-1:0]   acc;
  logic [DATA_W:0]       sum_hi;
  logic [2*DATA_W-1:0]   acc_next;
  logic [2*DATA_W-1:0]   prod;
  logic [DATA_W-1:0]     alu_res;
  logic                  accept;
  logic                  is_mult;
  logic                  mul_done;

  assign accept   = in_valid && in_ready;
  assign is_mult  = (alu_control == OP_MULT);
  assign alu_res  = alu_op(alu_control, operand_a, operand_b, shamt);
  assign mul_done = (state == MUL) && (cnt == CNT_LAST);

  // One shift-add step: conditional add into the upper half (with carry), then shift right.
  always_comb begin
    sum_hi   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next = {sum_hi, acc[DATA_W-1:1]};
    prod     = sign ? neg_prod(acc_next) : acc_next;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: leave IDLE on a MULT accept, return after the last iteration.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mult) state_next = MUL;
      MUL:     if (cnt == CNT_LAST)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: accept only when idle and out of reset.
  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  // Multiply datapath: operand latch at accept, one iteration per cycle in MUL.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept && is_mult) begin
      mcand  <= abs_val(operand_a);
      mplier <= abs_val(operand_b);
      sign   <= operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
      acc    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
    end
  end

  // Result registers, iteration counter and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      result    <= '0;
      hi        <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == MUL) cnt <= cnt + CNT_W'(1);
      if (accept && !is_mult) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end else if (accept) begin
        cnt <= '0;
      end else if (mul_done) begin
        hi        <= prod[2*DATA_W-1:DATA_W];
        result    <= prod[DATA_W-1:0];
        zero      <= (prod[DATA_W-1:0] == '0);
        out_valid <= 1'b1;
      end
    end
  end

endmodule
